microseq: RTL and testbench

MICROSEQ -- requirements
Module: microseq

---
 rtl/alu_types_pkg.sv | 18 +
 rtl/microseq_pkg.sv | 38 +++
 rtl/microseq_regs.sv | 40 ++++
 rtl/microseq.sv | 176 +++++++++++++++++
 tb/tb_microseq.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_types_pkg.sv
// ============================================================================
// Module : alu_types (package)
// Brief  : Command encoding shared by the micro-sequencer and the external ALU.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_types;

    typedef enum logic [1:0] {
        ALU_SUB = 2'd0,
        ALU_INC = 2'd1,
        ALU_OR  = 2'd2
    } cmd_t;

endpackage

`default_nettype wire

// File: rtl/microseq_pkg.sv
// ============================================================================
// Module : microseq_types (package)
// Brief  : Opcodes, instruction layout and state encoding for microseq.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package microseq_types;

    typedef logic [3:0] op_t;

    localparam op_t c_op_nop  = 4'd0;
    localparam op_t c_op_ldi  = 4'd1;
    localparam op_t c_op_sub  = 4'd2;
    localparam op_t c_op_inc  = 4'd3;
    localparam op_t c_op_or   = 4'd4;
    localparam op_t c_op_jz   = 4'd5;
    localparam op_t c_op_jmp  = 4'd6;
    localparam op_t c_op_halt = 4'd7;

    typedef struct packed {
        op_t         op;
        logic [1:0]  dst;
        logic [1:0]  a;
        logic [1:0]  b;
        logic [5:0]  rsvd;
        logic [15:0] imm;
    } instr_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/microseq_regs.sv
// ============================================================================
// Module : microseq_regs
// Brief  : 4x16 register file, two combinational reads, one synchronous write.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module microseq_regs (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  raddr_a,
    input  logic [1:0]  raddr_b,
    output logic [15:0] rdata_a,
    output logic [15:0] rdata_b,
    output logic [15:0] r0,
    input  logic        we,
    input  logic [1:0]  waddr,
    input  logic [15:0] wdata
);

    logic [15:0] r_mem [4];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata_a = r_mem[raddr_a];
    assign rdata_b = r_mem[raddr_b];
    // r0 is a fixed tap for the result port, not a general read port
    assign r0      = r_mem[0];

endmodule

`default_nettype wire

// File: rtl/microseq.sv
// ============================================================================
// Module : microseq
// Brief  : Single-issue micro-sequencer driving an external ALU.
//          Optional watchdog abort enabled by macro MICROSEQ_WDOG_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module microseq
    import microseq_types::*, alu_types::*;
#(
    parameter int PC_W       = 8,
    parameter int WDOG_LIMIT = 1000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [PC_W-1:0] pc,
    input  logic [31:0]     uinstr,
    output cmd_t            alu_cmd,
    output logic [15:0]     alu_x,
    output logic [15:0]     alu_y,
    input  logic [15:0]     alu_z,
    input  logic            alu_zflag,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [15:0]     result
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_nxt;
    logic            r_zf;

    instr_t          w_ins;
    logic            w_run;
    logic            w_accept;
    logic            w_alu_op;
    logic            w_halt;
    logic            w_abort;
    logic            w_we;
    logic [15:0]     w_wdata;
    logic [15:0]     w_ra;
    logic [15:0]     w_rb;
    logic [PC_W-1:0] w_target;
    logic            w_unused;

    assign w_ins    = instr_t'(uinstr);
    assign w_run    = (r_state == S_RUN);
    assign w_accept = (r_state == S_IDLE) && start;
    assign w_alu_op = (w_ins.op == c_op_sub) || (w_ins.op == c_op_inc) ||
                      (w_ins.op == c_op_or);
    assign w_halt   = (w_ins.op == c_op_halt);
    assign w_target = w_ins.imm[PC_W-1:0];
    assign w_unused = &{1'b0, w_ins.rsvd};

    assign w_we     = w_run && (w_alu_op || (w_ins.op == c_op_ldi));
    assign w_wdata  = (w_ins.op == c_op_ldi) ? w_ins.imm : alu_z;

    microseq_regs u_regs (
        .clk     (clk),
        .rst_n   (rst_n),
        .raddr_a (w_ins.a),
        .raddr_b (w_ins.b),
        .rdata_a (w_ra),
        .rdata_b (w_rb),
        .r0      (result),
        .we      (w_we),
        .waddr   (w_ins.dst),
        .wdata   (w_wdata)
    );

    // ALU operands are forced to a quiet SUB 0-0 for every non-ALU opcode
    always_comb begin
        alu_cmd = ALU_SUB;
        alu_x   = '0;
        alu_y   = '0;
        if (w_alu_op) begin
            alu_x = w_ra;
            alu_y = w_rb;
            case (w_ins.op)
                c_op_inc: alu_cmd = ALU_INC;
                c_op_or:  alu_cmd = ALU_OR;
                default:  alu_cmd = ALU_SUB;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_halt || w_abort) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_RUN);
        done = (r_state == S_DONE);
    end

    always_comb begin
        w_pc_nxt = r_pc;
        if (w_accept) begin
            w_pc_nxt = '0;
        end else if (w_run) begin
            case (w_ins.op)
                c_op_jmp: w_pc_nxt = w_target;
                c_op_jz:  w_pc_nxt = r_zf ? w_target : r_pc + PC_W'(1);
                default:  w_pc_nxt = r_pc + PC_W'(1);
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc <= '0;
            r_zf <= 1'b0;
        end else begin
            r_pc <= w_pc_nxt;
            if (w_run && w_alu_op) begin
                r_zf <= alu_zflag;
            end
        end
    end

    assign pc = r_pc;

`ifdef MICROSEQ_WDOG_EN
    localparam int CNT_W = $clog2(WDOG_LIMIT + 1);

    logic [CNT_W-1:0] r_icnt;
    logic             r_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_icnt <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_icnt <= '0;
                r_err  <= 1'b0;
            end else if (w_run) begin
                r_icnt <= r_icnt + CNT_W'(1);
                if (w_abort) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    // The LIMIT-th RUN cycle is the last one; a HALT in that cycle still counts as a clean finish
    assign w_abort = w_run && !w_halt && (r_icnt == CNT_W'(WDOG_LIMIT - 1));
    assign err     = r_err;
`else
    localparam int unused_wdog_limit = WDOG_LIMIT;

    assign w_abort = 1'b0;
    assign err     = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_microseq.sv
// ============================================================================
// Module : tb_microseq
// Brief  : Directed bench for microseq with a behavioural ALU and ROM.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_microseq;
    import microseq_types::*;
    import alu_types::*;

    localparam int PC_W = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [PC_W-1:0] pc;
    logic [31:0]     uinstr;
    cmd_t            alu_cmd;
    logic [15:0]     alu_x;
    logic [15:0]     alu_y;
    logic [15:0]     alu_z;
    logic            alu_zflag;
    logic            busy;
    logic            done;
    logic            err;
    logic [15:0]     result;

    logic [31:0]     rom [256];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    microseq #(.PC_W(PC_W), .WDOG_LIMIT(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .pc        (pc),
        .uinstr    (uinstr),
        .alu_cmd   (alu_cmd),
        .alu_x     (alu_x),
        .alu_y     (alu_y),
        .alu_z     (alu_z),
        .alu_zflag (alu_zflag),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .result    (result)
    );

    assign uinstr = rom[pc];

    always_comb begin
        case (alu_cmd)
            ALU_SUB: alu_z = alu_x - alu_y;
            ALU_INC: alu_z = alu_x + 16'd1;
            ALU_OR:  alu_z = alu_x | alu_y;
            default: alu_z = 16'h0000;
        endcase
        alu_zflag = (alu_z == 16'h0000);
    end

    function automatic logic [31:0] enc(input logic [3:0] op, input logic [1:0] d,
                                        input logic [1:0] a, input logic [1:0] b,
                                        input logic [15:0] imm);
        return {op, d, a, b, 6'b000000, imm};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = enc(c_op_nop, 2'd0, 2'd0, 2'd0, 16'h0);
    endtask

    // Pulse start from IDLE and wait (bounded) for done; counts RUN cycles on which pc==watch
    task automatic run(input logic [PC_W-1:0] watch, output int cyc, output int hits,
                       output logic [15:0] res, output logic [PC_W-1:0] pcd,
                       output logic errd, output logic busyd, output logic ok);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0; hits = 0; ok = 1'b0;
        res = '0; pcd = '0; errd = 1'b0; busyd = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (busy && pc == watch) hits++;
            @(negedge clk);
            cyc++;
            if (done) begin
                ok = 1'b1; res = result; pcd = pc; errd = err; busyd = busy;
                break;
            end
        end
        if (!ok) chk("done_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] exp_r0;
        logic        exp_zf;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int cyc, hits;
        logic [15:0] res;
        logic [PC_W-1:0] pcd;
        logic errd, busyd, ok;
        int wrap_pc [9];

        // LDI r1=x; LDI r2=y; op r0=r1,r2; JZ 5; HALT; HALT  -> final pc reveals zf
        vecs[0] = '{c_op_sub, 16'd5,    16'd5,    16'h0000, 1'b1};
        vecs[1] = '{c_op_sub, 16'd3,    16'd5,    16'hFFFE, 1'b0};
        vecs[2] = '{4'd9,     16'd1,    16'd1,    16'hFFFE, 1'b0};
        vecs[3] = '{c_op_inc, 16'hFFFF, 16'h1234, 16'h0000, 1'b1};
        vecs[4] = '{c_op_or,  16'h00F0, 16'h0F00, 16'h0FF0, 1'b0};
        vecs[5] = '{c_op_inc, 16'd7,    16'd0,    16'h0008, 1'b0};
        vecs[6] = '{c_op_or,  16'h0000, 16'h0000, 16'h0000, 1'b1};
        vecs[7] = '{c_op_sub, 16'h0000, 16'h0001, 16'hFFFF, 1'b0};
        vecs[8] = '{4'd12,    16'h0000, 16'h0000, 16'hFFFF, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        clear_rom();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_pc", 32'(pc), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_result", 32'(result), 32'd0);

        for (int v = 0; v < 9; v++) begin
            clear_rom();
            rom[0] = enc(c_op_ldi, 2'd1, 2'd0, 2'd0, vecs[v].x);
            rom[1] = enc(c_op_ldi, 2'd2, 2'd0, 2'd0, vecs[v].y);
            rom[2] = enc(vecs[v].op, 2'd0, 2'd1, 2'd2, 16'h0000);
            rom[3] = enc(c_op_jz, 2'd0, 2'd0, 2'd0, 16'd5);
            rom[4] = enc(c_op_halt, 2'd0, 2'd0, 2'd0, 16'h0);
            rom[5] = enc(c_op_halt, 2'd0, 2'd0, 2'd0, 16'h0);
            run(8'd0, cyc, hits, res, pcd, errd, busyd, ok);
            chk($sformatf("vec%0d_result", v), 32'(res), 32'(vecs[v].exp_r0));
            chk($sformatf("vec%0d_zf_pc", v), 32'(pcd), vecs[v].exp_zf ? 32'd6 : 32'd5);
            chk($sformatf("vec%0d_cycles", v), 32'(cyc), 32'd5);
            chk($sformatf("vec%0d_err", v), 32'(errd), 32'd0);
        end

        // load and subtract: done 4 cycles after start, single-cycle pulse
        clear_rom();
        rom[0] = enc(c_op_ldi, 2'd1, 2'd0, 2'd0, 16'd5);
        rom[1] = enc(c_op_ldi, 2'd2, 2'd0, 2'd0, 16'd5);
        rom[2] = enc(c_op_sub, 2'd0, 2'd1, 2'd2, 16'd0);
        rom[3] = enc(c_op_halt, 2'd0, 2'd0, 2'd0, 16'd0);
        run(8'd0, cyc, hits, res, pcd, errd, busyd, ok);
        chk("ldsub_cycles", 32'(cyc), 32'd4);
        chk("ldsub_result", 32'(res), 32'd0);
        chk("ldsub_pc", 32'(pcd), 32'd4);
        chk("ldsub_busy_in_done", 32'(busyd), 32'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ldsub_done_pulse", 32'(done), 32'd0);
        chk("ldsub_start_in_done", 32'(busy), 32'd0);
        chk("ldsub_result_held", 32'(result), 32'd0);
        chk("ldsub_pc_held", 32'(pc), 32'd4);

        // pc wrap with start ignored in RUN, then reset mid-run
        clear_rom();
        rom[0]   = enc(c_op_ldi, 2'd1, 2'd0, 2'd0, 16'd1);
        rom[1]   = enc(c_op_ldi, 2'd2, 2'd0, 2'd0, 16'd2);
        rom[2]   = enc(c_op_ldi, 2'd3, 2'd0, 2'd0, 16'd3);
        rom[3]   = enc(c_op_ldi, 2'd0, 2'd0, 2'd0, 16'd4);
        rom[4]   = enc(c_op_jmp, 2'd0, 2'd0, 2'd0, 16'd254);
        wrap_pc  = '{0, 1, 2, 3, 4, 254, 255, 0, 1};
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("wrap_pc%0d", i), 32'(pc), 32'(wrap_pc[i]));
            if (i == 5) start = 1'b1;
            if (i == 6) start = 1'b0;
            if (i < 8) @(negedge clk);
        end
        chk("wrap_r0_loaded", 32'(result), 32'd4);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rstrun_busy", 32'(busy), 32'd0);
        chk("rstrun_pc", 32'(pc), 32'd0);
        chk("rstrun_result", 32'(result), 32'd0);
        chk("rstrun_done", 32'(done), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rstrun_nodone%0d", i), 32'(done), 32'd0);
        end

        // r1..r3 and zf must be cleared by that reset
        clear_rom();
        rom[0] = enc(c_op_jz, 2'd0, 2'd0, 2'd0, 16'd4);
        rom[1] = enc(c_op_or, 2'd0, 2'd1, 2'd2, 16'd0);
        rom[2] = enc(c_op_or, 2'd0, 2'd0, 2'd3, 16'd0);
        rom[3] = enc(c_op_halt, 2'd0, 2'd0, 2'd0, 16'd0);
        rom[4] = enc(c_op_halt, 2'd0, 2'd0, 2'd0, 16'd0);
        run(8'd0, cyc, hits, res, pcd, errd, busyd, ok);
        chk("postrst_regs", 32'(res), 32'd0);
        chk("postrst_zf_pc", 32'(pcd), 32'd4);

`ifndef MICROSEQ_WDOG_EN
        // countdown loop runs past the watchdog limit without aborting
        clear_rom();
        rom[0] = enc(c_op_ldi, 2'd0, 2'd0, 2'd0, 16'h1234);
        rom[1] = enc(c_op_ldi, 2'd1, 2'd0, 2'd0, 16'd3);
        rom[2] = enc(c_op_ldi, 2'd2, 2'd0, 2'd0, 16'd1);
        rom[3] = enc(c_op_sub, 2'd1, 2'd1, 2'd2, 16'd0);
        rom[4] = enc(c_op_jz, 2'd0, 2'd0, 2'd0, 16'd6);
        rom[5] = enc(c_op_jmp, 2'd0, 2'd0, 2'd0, 16'd3);
        rom[6] = enc(c_op_or, 2'd0, 2'd1, 2'd1, 16'd0);
        rom[7] = enc(c_op_halt, 2'd0, 2'd0, 2'd0, 16'd0);
        run(8'd3, cyc, hits, res, pcd, errd, busyd, ok);
        chk("loop_body_count", 32'(hits), 32'd3);
        chk("loop_r1", 32'(res), 32'd0);
        chk("loop_cycles", 32'(cyc), 32'd13);
        chk("loop_err", 32'(errd), 32'd0);
`else
        // watchdog: JMP-to-self aborts after 10 RUN cycles; next start clears err
        clear_rom();
        rom[0] = enc(c_op_jmp, 2'd0, 2'd0, 2'd0, 16'd0);
        run(8'd0, cyc, hits, res, pcd, errd, busyd, ok);
        chk("wdog_cycles", 32'(cyc), 32'd10);
        chk("wdog_err", 32'(errd), 32'd1);
        chk("wdog_hits", 32'(hits), 32'd10);
        @(negedge clk);
        chk("wdog_err_sticky", 32'(err), 32'd1);
        clear_rom();
        rom[0] = enc(c_op_halt, 2'd0, 2'd0, 2'd0, 16'd0);
        run(8'd0, cyc, hits, res, pcd, errd, busyd, ok);
        chk("wdog_clear_cycles", 32'(cyc), 32'd1);
        chk("wdog_clear_err", 32'(errd), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
